dpd_conv_sched: RTL
===================

Name: dpd_conv_sched

Overview:
Shared, sequenced decimal-format conversion engine with two requester ports.
- Round-robin arbitration admits one request at a time.
- Any of binary / BCD / DPD input is converted to any of binary / BCD / DPD output.
- Binary input uses a multi-cycle double-dabble datapath; DPD packing and unpacking reuse the existing dpd_pack / dpd_unpack modules.
- Sits between on-chip requesters (host interface, test sequencer) and a single result consumer.

Parameters:
DABBLE_CYCLES, 10, number of shift/add-3 iterations for binary→BCD (fixed by the 10-bit operand width; must be 10).

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 accepted this cycle
req0_data  input  12  operand: bin/dpd in [9:0], [11:10] ignored; bcd in {d2,d1,d0}
req0_fmt  input  4  {in_fmt[1:0], out_fmt[1:0]}: 00 bin, 01 bcd, 10 dpd, 11 reserved
req1_valid / req1_ready / req1_data / req1_fmt  same as requester 0
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_data  output  12  result: bcd {d2,d1,d0}; bin/dpd zero-extended 10-bit
rsp_flags  output  4  bcd in: {any,d2≥10,d1≥10,d0≥10}; bin in: {000,in≥1000}; dpd in: 0000
rsp_err  output  1  reserved format code used
rsp_id  output  1  requester index of the result

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: FSM IDLE, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0, rsp_id=0, rr pointer favours req0, counter=0.
- States:
  - IDLE: arbitrate.
  - CONV: counter-driven.
  - DONE: hold result.
- Arbitration, in IDLE only:
  - reqN_ready=1 only for the granted requester, combinational from both valids.
  - Round-robin: requester not granted last wins a tie.
  - A single requester is granted regardless of the pointer.
  - Pointer updates only on accept. Outside IDLE both ready=0.
- Accept (cycle T):
  - Capture data, fmt and id.
  - Go to CONV with counter = 10 for in_fmt=bin, else 1.
- Input decode:
  - bin: if value ≥1000, subtract 1000 and set flags=0001. Then double-dabble one bit per CONV cycle.
  - bcd: digits pass unchanged, flags per digit. Invalid digits propagate as-is.
  - dpd: dpd_unpack, flags 0000.
  - Reserved in_fmt or out_fmt (11): rsp_data=0, flags=0, rsp_err=1. Latency is the non-bin latency.
- Output encode, computed on the last CONV cycle and registered:
  - bcd: digits.
  - dpd: dpd_pack(d2,d1,d0).
  - bin: d2*100+d1*10+d0 truncated to 10 bits.
- Latency: rsp_valid first high at T+2 for bcd/dpd/reserved inputs, T+11 for bin input.
- DONE:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid&rsp_ready: rsp_valid=0 next cycle, go to IDLE.
  - A new accept is possible no earlier than the cycle after the response handshake (no overlap).
- rst mid-CONV or mid-DONE: operation discarded, no response, state returns to reset values next cycle.
- Valid changes on an unaccepted requester are tolerated; the block doesn't require valid to be held.

Optional Feature:
FAST_BIN_EN:
- Defined: binary input is converted by combinational divide-by-100/10 in a single CONV cycle, so all latencies are T+2 and the dabble counter logic is removed.
- Undefined: 10-cycle double-dabble as above.
- Results are bit-identical either way.

Test Plan:
- req0 bin 0x3E7, fmt 0001 -> rsp_data 0x999, flags 0000, rsp_id 0, rsp_valid first at T+11 (T+2 with FAST_BIN_EN).
- req1 bin 0x3FF, fmt 0001 -> rsp_data 0x023, flags 0001.
- bcd 0x123, fmt 0110 -> rsp_data 0x0A3 at T+2; then dpd 0x0A3, fmt 1000 -> rsp_data 0x07B.
- bcd 0x1A5, fmt 0100 -> rsp_data 0x0CD, flags 1010; fmt 1100 -> rsp_data 0, rsp_err 1.
- Both valid continuously after reset, rsp_ready=1 -> grants alternate req0, req1, req0…; rsp_ready held 0 for 5 cycles -> rsp fields stable, no ready asserted.
- rst pulse at T+5 of a bin op -> no rsp_valid, next cycle IDLE, a subsequent tie is granted to req0.

Source files
------------

// File: rtl/dpd_conv_sched_if.sv
// Handshake bundle between the two requesters, the conversion engine and the result consumer.
// master: requester/consumer side (drives valid/data/fmt and rsp_ready).
// slave:  engine side (drives reqN_ready and the rsp_* result fields).
interface dpd_conv_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [11:0] req0_data;
  logic [3:0]  req0_fmt;
  logic        req1_valid;
  logic        req1_ready;
  logic [11:0] req1_data;
  logic [3:0]  req1_fmt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [11:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic        rsp_id;

  modport master (
    output req0_valid, req0_data, req0_fmt,
    output req1_valid, req1_data, req1_fmt,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_flags, rsp_err, rsp_id
  );

  modport slave (
    input  req0_valid, req0_data, req0_fmt,
    input  req1_valid, req1_data, req1_fmt,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_flags, rsp_err, rsp_id
  );
endinterface

// File: rtl/dpd_conv_sched.sv
// Shared two-port binary/BCD/DPD format converter, round-robin arbitrated, one op in flight.
// Latency: accept at T, rsp_valid at T+2 (bcd/dpd/reserved in) or T+11 (bin in; T+2 with FAST_BIN_EN).
// Backpressure: result held in DONE until rsp_ready; both reqN_ready stay low outside IDLE.
// Ports: clk, rst (sync, active-high); bus (dpd_conv_sched_if.slave): req0_*/req1_* valid/ready/data/fmt,
//        rsp_valid/rsp_ready/rsp_data/rsp_flags/rsp_err/rsp_id.
// Option: define FAST_BIN_EN for single-cycle divide-based binary->BCD instead of double-dabble.
module dpd_conv_sched #(
  parameter int DABBLE_CYCLES = 10
) (
  input  logic           clk,
  input  logic           rst,
  dpd_conv_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  localparam logic [1:0] F_BIN = 2'b00, F_BCD = 2'b01, F_DPD = 2'b10, F_RSV = 2'b11;

  // Densely packed decimal encode of three BCD digits {abcd, efgh, ijkm}.
  function automatic logic [9:0] dpd_pack(input logic [11:0] d);
    logic [9:0] p;
    case ({d[11], d[7], d[3]})
      3'b000:  p = {d[10:8], d[6:4], 1'b0, d[2:0]};
      3'b001:  p = {d[10:8], d[6:4], 3'b100, d[0]};
      3'b010:  p = {d[10:8], d[2:1], d[4], 3'b101, d[0]};
      3'b100:  p = {d[2:1], d[8], d[6:4], 3'b110, d[0]};
      3'b110:  p = {d[2:1], d[8], 2'b00, d[4], 3'b111, d[0]};
      3'b101:  p = {d[6:5], d[8], 2'b01, d[4], 3'b111, d[0]};
      3'b011:  p = {d[10:8], 2'b10, d[4], 3'b111, d[0]};
      default: p = {2'b00, d[8], 2'b11, d[4], 3'b111, d[0]};
    endcase
    return p;
  endfunction

  // Densely packed decimal decode to {d2, d1, d0}.
  function automatic logic [11:0] dpd_unpack(input logic [9:0] p);
    logic [11:0] d;
    if (!p[3])
      d = {1'b0, p[9:7], 1'b0, p[6:4], 1'b0, p[2:0]};
    else begin
      case (p[2:1])
        2'b00: d = {1'b0, p[9:7], 1'b0, p[6:4], 3'b100, p[0]};
        2'b01: d = {1'b0, p[9:7], 3'b100, p[4], 1'b0, p[6:5], p[0]};
        2'b10: d = {3'b100, p[7], 1'b0, p[6:4], 1'b0, p[9:8], p[0]};
        default: begin
          case (p[6:5])
            2'b00:   d = {3'b100, p[7], 3'b100, p[4], 1'b0, p[9:8], p[0]};
            2'b01:   d = {3'b100, p[7], 1'b0, p[9:8], p[4], 3'b100, p[0]};
            2'b10:   d = {1'b0, p[9:7], 3'b100, p[4], 3'b100, p[0]};
            default: d = {3'b100, p[7], 3'b100, p[4], 3'b100, p[0]};
          endcase
        end
      endcase
    end
    return d;
  endfunction

  // One double-dabble iteration on {bcd[11:0], bin[9:0]}: add-3 correction then shift left.
  function automatic logic [21:0] dabble_step(input logic [21:0] s);
    logic [21:0] t;
    t = s;
    for (int i = 0; i < 3; i++)
      if (t[10+4*i +: 4] >= 4'd5) t[10+4*i +: 4] = t[10+4*i +: 4] + 4'd3;
    return {t[20:0], 1'b0};
  endfunction

  state_t      state_q, state_d;
  logic        last_q;               // 1: req1 granted last, so req0 wins the next tie
  logic        grant0, grant1, accept, rsp_valid_c;
  logic [11:0] sel_data;
  logic [3:0]  sel_fmt;
  logic [9:0]  bin_val;
  logic [21:0] dec_sh;
  logic [3:0]  dec_flags;
  logic        dec_err;
  logic [21:0] sh_q;                 // digits in [21:10]; [9:0] holds the unshifted binary bits
  logic [3:0]  flags_q;
  logic        err_q, id_q;
  logic [1:0]  ofmt_q;
  logic        conv_last;
  logic [11:0] digits, enc;
  logic [9:0]  bin_sum;
  logic [11:0] rsp_data_q;
  logic [3:0]  rsp_flags_q;
  logic        rsp_err_q, rsp_id_q;
`ifdef FAST_BIN_EN
  function automatic logic [11:0] bin_to_bcd_div(input logic [9:0] v);
    logic [9:0] h, t, o;
    h = v / 10'd100;
    t = (v / 10'd10) % 10'd10;
    o = v % 10'd10;
    return {h[3:0], t[3:0], o[3:0]};
  endfunction
`else
  logic        dec_bin, bin_q;
  logic [3:0]  cnt_q;
  logic [21:0] dab;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CONV;
      CONV:    if (conv_last) state_d = DONE;
      DONE:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: grants are combinational from both valids, only in IDLE
  always_comb begin
    grant0      = 1'b0;
    grant1      = 1'b0;
    rsp_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        grant0 = bus.req0_valid && (!bus.req1_valid || last_q);
        grant1 = bus.req1_valid && (!bus.req0_valid || !last_q);
      end
      DONE:    rsp_valid_c = 1'b1;
      default: ;
    endcase
  end

  assign accept         = grant0 | grant1;
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp_valid  = rsp_valid_c;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_id     = rsp_id_q;

  // Input decode of the granted request
  always_comb begin
    sel_data  = grant1 ? bus.req1_data : bus.req0_data;
    sel_fmt   = grant1 ? bus.req1_fmt  : bus.req0_fmt;
    bin_val   = sel_data[9:0];
    dec_sh    = '0;
    dec_flags = '0;
    dec_err   = 1'b0;
`ifndef FAST_BIN_EN
    dec_bin   = 1'b0;
`endif
    if (sel_fmt[3:2] == F_RSV || sel_fmt[1:0] == F_RSV) begin
      dec_err = 1'b1;
    end else begin
      case (sel_fmt[3:2])
        F_BIN: begin
          // Values 1000..1023 wrap into 0..23 with the overflow flag set.
          if (bin_val >= 10'd1000) begin
            bin_val   = bin_val - 10'd1000;
            dec_flags = 4'b0001;
          end
`ifdef FAST_BIN_EN
          dec_sh = {bin_to_bcd_div(bin_val), 10'd0};
`else
          dec_sh  = {12'd0, bin_val};
          dec_bin = 1'b1;
`endif
        end
        F_BCD: begin
          dec_sh       = {sel_data, 10'd0};
          dec_flags[2] = sel_data[11:8] > 4'd9;
          dec_flags[1] = sel_data[7:4]  > 4'd9;
          dec_flags[0] = sel_data[3:0]  > 4'd9;
          dec_flags[3] = |dec_flags[2:0];
        end
        F_DPD:   dec_sh = {dpd_unpack(sel_data[9:0]), 10'd0};
        default: ;
      endcase
    end
  end

  // Digit source on the CONV cycle; for binary the final dabble step is folded in here.
  always_comb begin
`ifdef FAST_BIN_EN
    conv_last = 1'b1;
    digits    = sh_q[21:10];
`else
    dab       = dabble_step(sh_q);
    conv_last = (cnt_q == 4'd1);
    digits    = bin_q ? dab[21:10] : sh_q[21:10];
`endif
    bin_sum = 10'(digits[11:8]) * 10'd100 + 10'(digits[7:4]) * 10'd10 + 10'(digits[3:0]);
    case (ofmt_q)
      F_BCD:   enc = digits;
      F_DPD:   enc = {2'b00, dpd_pack(digits)};
      F_BIN:   enc = {2'b00, bin_sum};
      default: enc = '0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= 1'b1;
      sh_q        <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
      id_q        <= 1'b0;
      ofmt_q      <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= 1'b0;
`ifndef FAST_BIN_EN
      bin_q       <= 1'b0;
      cnt_q       <= '0;
`endif
    end else begin
      if (accept) begin
        last_q  <= grant1;
        id_q    <= grant1;
        sh_q    <= dec_sh;
        flags_q <= dec_flags;
        err_q   <= dec_err;
        ofmt_q  <= sel_fmt[1:0];
`ifndef FAST_BIN_EN
        bin_q   <= dec_bin;
        cnt_q   <= dec_bin ? 4'(DABBLE_CYCLES) : 4'd1;
`endif
      end
      if (state_q == CONV) begin
`ifndef FAST_BIN_EN
        if (bin_q) sh_q <= dab;
        cnt_q <= cnt_q - 4'd1;
`endif
        if (conv_last) begin
          rsp_data_q  <= err_q ? 12'd0 : enc;
          rsp_flags_q <= err_q ? 4'd0  : flags_q;
          rsp_err_q   <= err_q;
          rsp_id_q    <= id_q;
        end
      end
    end
  end

endmodule
